// File: rtl/sram_capture_reader.sv
// rtl/sram_capture_reader.sv - read-back of the circular capture SRAM to the MCU byte port
//
// Walks LENGTH words starting at START_ADDR (wrapping silently at 2**ADDR_W).
// Each word is fetched RD_LAT+1 cycles after its address is driven. It is then
// handed to the MCU as the channel A byte followed by the channel B byte, one
// byte per MCU_RD strobe.
//
// Optional build macro: MINMAX_ORDER_EN
//   When defined and MINMAX_MODE was high at START, both words of each
//   min/max pair are fetched before the first byte goes out. The bytes of each
//   channel are swapped if needed so that the smaller byte is emitted first. A
//   trailing odd word is emitted unchanged. Without the macro, words always go
//   out in SRAM order.
//
// Ports
//   CLK                  system clock, rising edge
//   RESET                synchronous active-high reset
//   START                pulse: begin a read-back (only taken in IDLE)
//   ABORT                pulse: end the read-back early (ignored in IDLE)
//   START_ADDR           first word address, latched on accepted START
//   LENGTH               word count, 0 means 2**ADDR_W, latched on accepted START
//   MINMAX_MODE          buffer holds min/max pairs, latched on accepted START
//   SRAM_ADDR            SRAM word address
//   SRAM_OE_N            SRAM output enable, active low
//   SRAM_DATA_A          SRAM low byte (channel A)
//   SRAM_DATA_B          SRAM high byte (channel B)
//   MCU_RD               MCU consumed the current MCU_DATA
//   MCU_DATA             byte presented to the MCU
//   DATA_VALID           MCU_DATA holds an unconsumed byte
//   BUSY                 not in IDLE
//   DONE                 one-cycle pulse at the end of a read-back or on ABORT

module sram_capture_reader #(
    parameter int ADDR_W = 19,
    parameter int RD_LAT = 2
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              START,
    input  logic              ABORT,
    input  logic [ADDR_W-1:0] START_ADDR,
    input  logic [ADDR_W-1:0] LENGTH,
    input  logic              MINMAX_MODE,
    output logic [ADDR_W-1:0] SRAM_ADDR,
    output logic              SRAM_OE_N,
    input  logic [7:0]        SRAM_DATA_A,
    input  logic [7:0]        SRAM_DATA_B,
    input  logic              MCU_RD,
    output logic [7:0]        MCU_DATA,
    output logic              DATA_VALID,
    output logic              BUSY,
    output logic              DONE
);

    // One extra bit so that LENGTH=0 can stand for a full buffer.
    localparam int CNT_W = ADDR_W + 1;
    localparam logic [2:0] LAT = 3'(RD_LAT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_BYTE_A,
        S_BYTE_B,
        S_FIN
    } state_t;

    state_t            state;
    state_t            state_nx;

    logic [ADDR_W-1:0] addr_q;
    logic [CNT_W-1:0]  word_cnt;
    logic [2:0]        wait_cnt;
    logic [7:0]        word_a;
    logic [7:0]        word_b;
    logic              oe_n_q;
    logic              valid_q;
    logic              busy_q;
    logic              done_q;

    logic              fetch_done;
    logic              abort_acc;
    logic              rd_b;
    logic              last_word;
    logic              pair_first;
    logic              pending_word;

`ifdef MINMAX_ORDER_EN
    logic              mode_q;
    logic              fetch_second;
    logic              pending_q;
    logic [7:0]        pair_a;
    logic [7:0]        pair_b;

    // First word of a pair with a partner still left in the transfer: keep it
    // and fetch the next address before anything is shown to the MCU.
    assign pair_first   = (state == S_FETCH) && fetch_done && mode_q && !fetch_second
                          && (word_cnt > CNT_W'(1));
    assign pending_word = pending_q;
`else
    logic              unused_mode;

    assign unused_mode  = MINMAX_MODE;
    assign pair_first   = 1'b0;
    assign pending_word = 1'b0;
`endif

    // The address has been held long enough; the data bus is sampled this edge.
    assign fetch_done = (wait_cnt == LAT);
    // FIN already ends the transfer; sending it back to FIN would stretch DONE.
    assign abort_acc  = ABORT && (state != S_IDLE) && (state != S_FIN);
    assign rd_b       = (state == S_BYTE_B) && MCU_RD && !ABORT;
    assign last_word  = (word_cnt == CNT_W'(1));

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (START) begin
                    state_nx = S_FETCH;
                end
            end
            S_FETCH: begin
                if (fetch_done && !pair_first) begin
                    state_nx = S_BYTE_A;
                end
            end
            S_BYTE_A: begin
                if (MCU_RD) begin
                    state_nx = S_BYTE_B;
                end
            end
            S_BYTE_B: begin
                if (MCU_RD) begin
                    if (pending_word) begin
                        state_nx = S_BYTE_A;
                    end else if (last_word) begin
                        state_nx = S_FIN;
                    end else begin
                        state_nx = S_FETCH;
                    end
                end
            end
            S_FIN: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
        if (abort_acc) begin
            state_nx = S_FIN;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            addr_q       <= '0;
            word_cnt     <= '0;
            wait_cnt     <= '0;
            word_a       <= '0;
            word_b       <= '0;
            oe_n_q       <= 1'b1;
            valid_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
`ifdef MINMAX_ORDER_EN
            mode_q       <= 1'b0;
            fetch_second <= 1'b0;
            pending_q    <= 1'b0;
            pair_a       <= '0;
            pair_b       <= '0;
`endif
        end else begin
            // Status outputs are registered from the next state so that
            // they line up with the state they describe.
            oe_n_q  <= !((state_nx == S_FETCH) || (state_nx == S_BYTE_A) ||
                         (state_nx == S_BYTE_B));
            valid_q <= (state_nx == S_BYTE_A) || (state_nx == S_BYTE_B);
            busy_q  <= (state_nx != S_IDLE);
            done_q  <= (state_nx == S_FIN);

            case (state)
                S_IDLE: begin
                    if (START) begin
                        addr_q   <= START_ADDR;
                        word_cnt <= (LENGTH == '0) ? (CNT_W'(1) << ADDR_W)
                                                   : {1'b0, LENGTH};
                        wait_cnt <= '0;
`ifdef MINMAX_ORDER_EN
                        mode_q       <= MINMAX_MODE;
                        fetch_second <= 1'b0;
                        pending_q    <= 1'b0;
`endif
                    end
                end
                S_FETCH: begin
                    if (!fetch_done) begin
                        wait_cnt <= wait_cnt + 3'd1;
                    end else begin
                        wait_cnt <= '0;
`ifdef MINMAX_ORDER_EN
                        if (fetch_second) begin
                            // Per-channel ordering: the current word takes the minimum,
                            // and the buffered partner takes the maximum.
                            word_a       <= (word_a > SRAM_DATA_A) ? SRAM_DATA_A : word_a;
                            pair_a       <= (word_a > SRAM_DATA_A) ? word_a : SRAM_DATA_A;
                            word_b       <= (word_b > SRAM_DATA_B) ? SRAM_DATA_B : word_b;
                            pair_b       <= (word_b > SRAM_DATA_B) ? word_b : SRAM_DATA_B;
                            pending_q    <= 1'b1;
                            fetch_second <= 1'b0;
                        end else begin
                            word_a <= SRAM_DATA_A;
                            word_b <= SRAM_DATA_B;
                            if (pair_first) begin
                                fetch_second <= 1'b1;
                                addr_q       <= addr_q + ADDR_W'(1);
                            end
                        end
`else
                        word_a <= SRAM_DATA_A;
                        word_b <= SRAM_DATA_B;
`endif
                    end
                end
                S_BYTE_B: begin
                    if (rd_b) begin
                        word_cnt <= word_cnt - CNT_W'(1);
`ifdef MINMAX_ORDER_EN
                        if (pending_q) begin
                            // The address already points at this buffered word.
                            word_a    <= pair_a;
                            word_b    <= pair_b;
                            pending_q <= 1'b0;
                        end else begin
                            addr_q <= addr_q + ADDR_W'(1);
                        end
`else
                        addr_q <= addr_q + ADDR_W'(1);
`endif
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign SRAM_ADDR  = addr_q;
    assign SRAM_OE_N  = oe_n_q;
    assign DATA_VALID = valid_q;
    assign BUSY       = busy_q;
    assign DONE       = done_q;
    assign MCU_DATA   = (state == S_BYTE_A) ? word_a :
                        (state == S_BYTE_B) ? word_b : 8'h00;

endmodule
